// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the multicycle ALU: opcode encodings, the
//   controller state encoding and the width of the iteration counter used
//   by the shift-add / restoring-division datapath.
//   No ports (package).
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Counter must be able to hold the value WIDTH, hence clog2(WIDTH+1).
  function automatic int iter_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter
//   Iterative unsigned multiplier (shift-add) and divider (restoring),
//   one iteration per clock, WIDTH iterations per operation. The operands
//   are captured on the start edge; the following WIDTH edges each perform
//   one iteration. During the cycle of the last iteration 'done' is high and
//   res_lo/res_hi already show the final values, so the owner can capture
//   the result on the same edge that completes the operation.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           load operands and begin an operation
//   op_div          1 = divide, 0 = multiply (sampled with start)
//   a, b            operands (a*b or a/b)
//   done            last iteration is happening this cycle
//   res_lo          product low half / quotient
//   res_hi          product high half / remainder
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  localparam int CW = iter_cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             busy;
  logic             div_q;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opnd_q;

  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // hi/lo are shared: for multiply they form the {accumulator, multiplier}
  // shift register, for divide they are {partial remainder, quotient}.
  always_comb begin
    sum     = {1'b0, hi_q} + {1'b0, opnd_q};
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff    = shifted - {1'b0, opnd_q};
    hi_next = hi_q;
    lo_next = lo_q;
    if (div_q) begin
      // Partial remainder stays below the divisor, so a successful trial
      // subtraction always fits back into WIDTH bits.
      if (shifted >= {1'b0, opnd_q}) begin
        hi_next = diff[WIDTH-1:0];
        lo_next = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = shifted[WIDTH-1:0];
        lo_next = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (lo_q[0]) begin
        {hi_next, lo_next} = {sum, lo_q[WIDTH-1:1]};
      end else begin
        {hi_next, lo_next} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
      end
    end
  end

  assign done   = busy && (count == LAST);
  assign res_lo = lo_next;
  assign res_hi = hi_next;

  // Operand load on start, then one iteration per cycle while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      div_q  <= 1'b0;
      count  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      div_q  <= op_div;
      count  <= '0;
      hi_q   <= '0;
      lo_q   <= op_div ? a : b;
      opnd_q <= op_div ? b : a;
    end else if (busy) begin
      hi_q <= hi_next;
      lo_q <= lo_next;
      if (done) begin
        busy  <= 1'b0;
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle
//   Unsigned ALU with valid/ready handshakes. Single-cycle operations
//   (add, sub, and, or, xor, compare, divide-by-zero) complete on the accept
//   edge; multiply and divide run WIDTH iterations in alu_muldiv_iter.
//   The result is held in DONE until the consumer takes it.
//   Optional feature: define ALU_MULTICYCLE_REM_EN to add rem_out
//   (division remainder).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready request handshake (a, b, alu_sel)
//   a, b, alu_sel     operands and opcode
//   out_valid/out_ready result handshake
//   alu_out           result
//   carry_out         carry / borrow / mul overflow / divide-by-zero
//   zero_out          alu_out == 0
//   rem_out           remainder (only with ALU_MULTICYCLE_REM_EN)
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry_out,
  output logic             zero_out
`ifdef ALU_MULTICYCLE_REM_EN
  ,
  output logic [WIDTH-1:0] rem_out
`endif
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic             iter_start;
  logic             iter_done;
  logic [WIDTH-1:0] iter_lo;
  logic [WIDTH-1:0] iter_hi;
  logic [WIDTH-1:0] simple_res;
  logic             simple_carry;
  logic [WIDTH:0]   add_full;
  logic             b_is_zero;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign b_is_zero = (b == '0);

  // Iterator starts only for multiply and non-zero divide; divide by zero
  // is resolved immediately as a single-cycle operation.
  assign iter_start = in_ready && in_valid &&
                      ((alu_sel == OP_MUL) || ((alu_sel == OP_DIV) && !b_is_zero));

  alu_muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (iter_start),
    .op_div (alu_sel == OP_DIV),
    .a      (a),
    .b      (b),
    .done   (iter_done),
    .res_lo (iter_lo),
    .res_hi (iter_hi)
  );

  // Results of the operations that finish on the accept edge.
  always_comb begin
    add_full     = {1'b0, a} + {1'b0, b};
    simple_res   = '0;
    simple_carry = 1'b0;
    case (alu_sel)
      OP_ADD: {simple_carry, simple_res} = add_full;
      OP_SUB: begin
        simple_res   = a - b;
        simple_carry = (a < b);
      end
      OP_AND: simple_res = a & b;
      OP_OR:  simple_res = a | b;
      OP_XOR: simple_res = a ^ b;
      OP_CMP: simple_res = (a == b) ? ONE : '0;
      OP_DIV: simple_carry = 1'b1;
      default: begin
        simple_res   = '0;
        simple_carry = 1'b0;
      end
    endcase
  end

  // Controller: accepts in IDLE, waits for the iterator in MUL/DIV and
  // holds the registered result in DONE until out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      alu_out   <= '0;
      carry_out <= 1'b0;
      zero_out  <= 1'b1;
`ifdef ALU_MULTICYCLE_REM_EN
      rem_out   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (alu_sel == OP_MUL) begin
              state <= ST_MUL;
            end else if ((alu_sel == OP_DIV) && !b_is_zero) begin
              state <= ST_DIV;
            end else begin
              state     <= ST_DONE;
              alu_out   <= simple_res;
              carry_out <= simple_carry;
              zero_out  <= (simple_res == '0);
`ifdef ALU_MULTICYCLE_REM_EN
              rem_out   <= '0;
`endif
            end
          end
        end
        ST_MUL: begin
          if (iter_done) begin
            state     <= ST_DONE;
            alu_out   <= iter_lo;
            carry_out <= |iter_hi;
            zero_out  <= (iter_lo == '0);
`ifdef ALU_MULTICYCLE_REM_EN
            rem_out   <= '0;
`endif
          end
        end
        ST_DIV: begin
          if (iter_done) begin
            state     <= ST_DONE;
            alu_out   <= iter_lo;
            carry_out <= 1'b0;
            zero_out  <= (iter_lo == '0);
`ifdef ALU_MULTICYCLE_REM_EN
            rem_out   <= iter_hi;
`endif
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle
//   Directed self-checking bench for alu_multicycle at WIDTH=8.
//   Build with ALU_MULTICYCLE_REM_EN defined to also check rem_out.
module tb_alu_multicycle;
  import alu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] alu_sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] alu_out;
  logic       carry_out;
  logic       zero_out;
`ifdef ALU_MULTICYCLE_REM_EN
  logic [7:0] rem_out;
`endif

  int checks = 0;
  int errors = 0;

  alu_multicycle #(
    .WIDTH(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .alu_sel   (alu_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .carry_out (carry_out),
    .zero_out  (zero_out)
`ifdef ALU_MULTICYCLE_REM_EN
    ,
    .rem_out   (rem_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, and on mismatch count and report it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present a request at the falling edge, hold it through the accept edge,
  // then scramble the inputs so the in-flight result cannot depend on them.
  task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb_v,
                               input logic [2:0] sel, input string tag);
    @(negedge clk);
    a        = ta;
    b        = tb_v;
    alu_sel  = sel;
    in_valid = 1'b1;
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 8'($urandom);
    b        = 8'($urandom);
    alu_sel  = 3'($urandom);
  endtask

  // Count rising edges after the accept edge until out_valid, bounded.
  task automatic waitResult(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic releaseResult(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
  endtask

  task automatic runOp(input logic [7:0] ta, input logic [7:0] tb_v,
                       input logic [2:0] sel, input int exp_lat,
                       input logic [7:0] exp_out, input logic exp_carry,
                       input logic [7:0] exp_rem, input string tag);
    int lat;
    applyStimulus(ta, tb_v, sel, tag);
    waitResult(lat);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_out"}, 32'(alu_out), 32'(exp_out));
    checkOutput({tag, "_carry"}, 32'(carry_out), 32'(exp_carry));
    checkOutput({tag, "_zero"}, 32'(zero_out), 32'(exp_out == 8'h00));
`ifdef ALU_MULTICYCLE_REM_EN
    checkOutput({tag, "_rem"}, 32'(rem_out), 32'(exp_rem));
`else
    if (exp_rem != exp_rem) $display("[TB] unreachable");
`endif
    releaseResult(tag);
  endtask

  initial begin
    int seen;
    int lat;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    alu_sel   = '0;

    #12;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_alu_out", 32'(alu_out), 32'd0);
    checkOutput("rst_carry", 32'(carry_out), 32'd0);
    checkOutput("rst_zero", 32'(zero_out), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle operations: result visible right after the accept edge.
    runOp(8'hF0, 8'h20, OP_ADD, 0, 8'h10, 1'b1, 8'h00, "add_carry");
    runOp(8'h12, 8'h34, OP_ADD, 0, 8'h46, 1'b0, 8'h00, "add_plain");
    runOp(8'h05, 8'h07, OP_SUB, 0, 8'hFE, 1'b1, 8'h00, "sub_borrow");
    runOp(8'h07, 8'h07, OP_SUB, 0, 8'h00, 1'b0, 8'h00, "sub_zero");
    runOp(8'hAA, 8'h0F, OP_AND, 0, 8'h0A, 1'b0, 8'h00, "and");
    runOp(8'hA0, 8'h05, OP_OR,  0, 8'hA5, 1'b0, 8'h00, "or");
    runOp(8'hFF, 8'h0F, OP_XOR, 0, 8'hF0, 1'b0, 8'h00, "xor");
    runOp(8'h3C, 8'h3C, OP_CMP, 0, 8'h01, 1'b0, 8'h00, "cmp_eq");
    runOp(8'h3C, 8'h3D, OP_CMP, 0, 8'h00, 1'b0, 8'h00, "cmp_ne");

    // Iterative operations: 8 further edges after accept.
    runOp(8'd16, 8'd17, OP_MUL, 8, 8'h10, 1'b1, 8'h00, "mul_ovf");
    runOp(8'h00, 8'hFF, OP_MUL, 8, 8'h00, 1'b0, 8'h00, "mul_zero");
    runOp(8'h0F, 8'h0F, OP_MUL, 8, 8'hE1, 1'b0, 8'h00, "mul_fit");
    runOp(8'hFF, 8'hFF, OP_MUL, 8, 8'h01, 1'b1, 8'h00, "mul_max");
    runOp(8'd200, 8'd7, OP_DIV, 8, 8'h1C, 1'b0, 8'h04, "div");
    runOp(8'h05, 8'h09, OP_DIV, 8, 8'h00, 1'b0, 8'h05, "div_small");
    runOp(8'hFF, 8'h01, OP_DIV, 8, 8'hFF, 1'b0, 8'h00, "div_by_one");
    runOp(8'h55, 8'h00, OP_DIV, 0, 8'h00, 1'b1, 8'h00, "div_by_zero");

    // Result held in DONE while out_ready is low; new requests ignored.
    applyStimulus(8'h03, 8'h05, OP_MUL, "hold");
    waitResult(lat);
    checkOutput("hold_latency", 32'(lat), 32'd8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a        = 8'h01;
      b        = 8'h01;
      alu_sel  = OP_ADD;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      checkOutput("hold_out", 32'(alu_out), 32'h0F);
      checkOutput("hold_carry", 32'(carry_out), 32'd0);
      checkOutput("hold_zero", 32'(zero_out), 32'd0);
    end
    in_valid = 1'b0;
    releaseResult("hold");
    checkOutput("hold_out_after", 32'(alu_out), 32'h0F);

    // Reset in the middle of a multiply abandons it.
    applyStimulus(8'd16, 8'd17, OP_MUL, "abort");
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort_zero", 32'(zero_out), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    checkOutput("abort_no_result", 32'(seen), 32'd0);
    runOp(8'h01, 8'h02, OP_ADD, 0, 8'h03, 1'b0, 8'h00, "after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
